cim_gemm_engine: RTL and testbench
==================================

// Module: cim_gemm_engine
// PURPOSE
//   Parametrised successor to the basic GeMM CIM macro. Holds a multi-entry signed weight array of NUM_COLS columns.
//   Computes NUM_COLS dot products of one ROWS-wide activation vector, bit-serially (one activation bit per cycle).
//   Accumulates results into per-column output registers. Sits on the core's CIM bus; busy/done handshake to the controller.
// PARAMETERS
//   ROWS      4   weights/activations per dot product
//   WEIGHT_W  8   signed weight width
//   ACT_W     8   activation width = bit-serial cycle count
//   NUM_COLS  8   output channels (power of 2)
//   DEPTH     4   weight entries per column (power of 2); ENT_W=clog2(DEPTH), COL_W=clog2(NUM_COLS)
//   ACC_W     32  output register width
//   DATA_W    32  bus width; constraint DATA_W == ROWS*WEIGHT_W == ROWS*ACT_W (elaboration error otherwise)
// PORTS
//   clk               in   1            clock, rising edge
//   rst_n             in   1            async active-low reset
//   cs                in   1            chip select; all bus ops qualified by cs
//   web               in   1            1 = weight write, 0 = read/execute
//   cimeb             in   1            active-low compute enable
//   partial_sum_eb    in   1            execute strobe (with cs & ~web & ~cimeb)
//   reset_output_reg  in   1            synchronous clear of all output registers
//   output_reg        in   4            output register select for cim_output
//   address           in   32           [ENT_W-1:0]=entry, [ENT_W+:COL_W]=column; upper bits ignored
//   input_data        in   DATA_W       write: weights, row r at [r*WEIGHT_W+:WEIGHT_W]; exec: activation r at [r*ACT_W+:ACT_W]
//   mem_output        out  DATA_W       registered weight read data
//   cim_output        out  ACC_W        out_reg[output_reg], combinational
//   busy              out  1            state != IDLE
//   done              out  1            one-cycle pulse, result committed
// BEHAVIOUR
//   Reset: state=IDLE, bit_cnt=0, temp accumulators=0, out_reg[*]=0, mem_output=0, done=0. Weight array NOT reset.
//   Write: cs&web&~busy -> array[col][entry] <= input_data at edge. Write while busy dropped.
//   Read: cs&~web&cimeb -> mem_output <= array[col][entry]; 1-cycle latency; allowed while busy.
//   Execute request: cs&~web&~cimeb&partial_sum_eb.
//     Accepted only in IDLE: latch activations and entry, temp<=0, bit_cnt<=0, ->RUN.
//     Ignored (not queued) while busy.
//   RUN: each edge processes bit b=bit_cnt.
//     colsum[c] = signed sum over r of (act[r][b] ? w[c][entry][r] : 0), width WEIGHT_W+clog2(ROWS)+1.
//     temp[c] += colsum[c] << b (sign-extended to ACC_W). At b==ACT_W-1 ->COMMIT.
//   COMMIT: out_reg[c] <= out_reg[c] + temp[c] (wrap mod 2^ACC_W); done<=1 for one cycle; ->IDLE.
//   Latency: acceptance edge E0; done high after edge E0+ACT_W+1. busy high E0..E0+ACT_W+1.
//   reset_output_reg: clears all out_reg; any state.
//     Same edge as COMMIT: clear wins, result discarded, done still pulses.
//   cim_output = 0 when output_reg >= NUM_COLS. Column index >= NUM_COLS on write: ignored; on read: mem_output <= 0.
//   rst_n mid-RUN: operation aborted, no done, accumulators cleared, weights retained.
// CONFIGURATION
//   CIM_SIGNED_ACT_EN defined: activations two's complement; MSB bit-plane (b==ACT_W-1) is subtracted, not added.
//   Undefined: activations unsigned, all bit-planes added.
// TESTING (defaults)
//   write addr0=0x03020100; read addr0 -> mem_output=0x03020100 one cycle later.
//   col0 e0=0x03020100 (addr0), col1 e0=0x07060504 (addr4); exec 0x01010101 -> done after 9 edges.
//     out0=6, out1=22. Exec 0x02020202 -> out0=18, out1=66.
//   col2 e0=0xFFFFFFFF; reset_output_reg; exec 0x000000FF -> out2=0xFFFFFF01 (-255).
//   exec request during RUN ignored: single done, values as single op; write during busy leaves array unchanged.
//   rst_n low mid-RUN -> busy=0, done=0, out_reg=0; subsequent exec computes correctly with retained weights.
//   col0 e0 weight row0=1, exec 0x000000FF: macro defined -> out0=0xFFFFFFFF; undefined -> out0=255.

Source files
------------

// File: rtl/cim_gemm_engine_if.sv
// CIM bus between the core controller and cim_gemm_engine.
// The master side drives commands and data; the slave side returns read data, results and the busy/done handshake.
interface cim_gemm_engine_if #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 32
) ();
    logic              cs;
    logic              web;
    logic              cimeb;
    logic              partial_sum_eb;
    logic              reset_output_reg;
    logic [3:0]        output_reg;
    logic [31:0]       address;
    logic [DATA_W-1:0] input_data;
    logic [DATA_W-1:0] mem_output;
    logic [ACC_W-1:0]  cim_output;
    logic              busy;
    logic              done;

    modport master (
        output cs, web, cimeb, partial_sum_eb, reset_output_reg, output_reg, address, input_data,
        input  mem_output, cim_output, busy, done
    );

    modport slave (
        input  cs, web, cimeb, partial_sum_eb, reset_output_reg, output_reg, address, input_data,
        output mem_output, cim_output, busy, done
    );
endinterface

// File: rtl/cim_gemm_engine.sv
// Bit-serial compute-in-memory GeMM engine: NUM_COLS signed dot products over a ROWS-wide activation vector.
// Optional feature macro: CIM_SIGNED_ACT_EN (two's-complement activations, MSB bit-plane subtracted).
module cim_gemm_engine #(
    parameter int ROWS     = 4,
    parameter int WEIGHT_W = 8,
    parameter int ACT_W    = 8,
    parameter int NUM_COLS = 8,
    parameter int DEPTH    = 4,
    parameter int ACC_W    = 32,
    parameter int DATA_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    cim_gemm_engine_if.slave   bus
);
    localparam int ENT_W = $clog2(DEPTH);
    localparam int COL_W = $clog2(NUM_COLS);
    localparam int BC_W  = $clog2(ACT_W);
    localparam int CS_W  = WEIGHT_W + $clog2(ROWS) + 1;

    generate
        if ((DATA_W != ROWS * WEIGHT_W) || (DATA_W != ROWS * ACT_W)) begin : g_bad_widths
            $error("cim_gemm_engine: DATA_W must equal ROWS*WEIGHT_W and ROWS*ACT_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nx_s;
    logic [DATA_W-1:0] weight_r [NUM_COLS][DEPTH];
    logic [DATA_W-1:0] act_r;
    logic [ENT_W-1:0]  entry_r;
    logic [BC_W-1:0]   bit_cnt_r;
    logic [ACC_W-1:0]  temp_r [NUM_COLS];
    logic [ACC_W-1:0]  out_r  [NUM_COLS];
    logic [DATA_W-1:0] mem_output_r;
    logic              done_r;

    logic [ENT_W-1:0]  entry_s;
    logic [COL_W-1:0]  col_s;
    logic              busy_s;
    logic              wr_en_s;
    logic              rd_en_s;
    logic              exec_req_s;
    logic              last_bit_s;
    logic [DATA_W-1:0] act_sh_s;
    logic [CS_W-1:0]   colsum_s [NUM_COLS];
    logic [ACC_W-1:0]  addend_s [NUM_COLS];

    assign entry_s    = bus.address[ENT_W-1:0];
    assign col_s      = bus.address[ENT_W +: COL_W];
    assign busy_s     = (state_r != ST_IDLE);
    assign wr_en_s    = bus.cs & bus.web & ~busy_s;
    assign rd_en_s    = bus.cs & ~bus.web & bus.cimeb;
    assign exec_req_s = bus.cs & ~bus.web & ~bus.cimeb & bus.partial_sum_eb;
    assign last_bit_s = (bit_cnt_r == BC_W'(ACT_W - 1));
    // Bit b of every activation lands at position r*ACT_W after the shift
    assign act_sh_s   = act_r >> bit_cnt_r;

    assign bus.busy       = busy_s;
    assign bus.done       = done_r;
    assign bus.mem_output = mem_output_r;

    // Result select; out-of-range selectors read as zero
    always_comb begin
        bus.cim_output = '0;
        if (32'(bus.output_reg) < NUM_COLS) begin
            bus.cim_output = out_r[bus.output_reg[COL_W-1:0]];
        end else begin
            bus.cim_output = '0;
        end
    end

    // Per-column bit-plane sum and its shifted, sign-extended contribution to the accumulator
    always_comb begin
        for (int c = 0; c < NUM_COLS; c++) begin
            colsum_s[c] = '0;
            for (int r = 0; r < ROWS; r++) begin
                if (act_sh_s[r*ACT_W]) begin
                    colsum_s[c] = colsum_s[c] +
                        {{(CS_W-WEIGHT_W){weight_r[c][entry_r][r*WEIGHT_W+WEIGHT_W-1]}},
                         weight_r[c][entry_r][r*WEIGHT_W +: WEIGHT_W]};
                end else begin
                    colsum_s[c] = colsum_s[c];
                end
            end
            addend_s[c] = {{(ACC_W-CS_W){colsum_s[c][CS_W-1]}}, colsum_s[c]} << bit_cnt_r;
`ifdef CIM_SIGNED_ACT_EN
            if (last_bit_s) begin
                addend_s[c] = ACC_W'(0) - addend_s[c];
            end else begin
                addend_s[c] = addend_s[c];
            end
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (exec_req_s) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_bit_s) begin
                    state_nx_s = ST_COMMIT;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_COMMIT: state_nx_s = ST_IDLE;
            default:   state_nx_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Weight array keeps its contents across reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            weight_r[col_s][entry_s] <= bus.input_data;
        end
    end

    // Operand latch and bit-serial accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_r     <= '0;
            entry_r   <= '0;
            bit_cnt_r <= '0;
            for (int c = 0; c < NUM_COLS; c++) temp_r[c] <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (exec_req_s) begin
                        act_r     <= bus.input_data;
                        entry_r   <= entry_s;
                        bit_cnt_r <= '0;
                        for (int c = 0; c < NUM_COLS; c++) temp_r[c] <= '0;
                    end
                end
                ST_RUN: begin
                    bit_cnt_r <= bit_cnt_r + BC_W'(1);
                    for (int c = 0; c < NUM_COLS; c++) temp_r[c] <= temp_r[c] + addend_s[c];
                end
                default: ;
            endcase
        end
    end

    // Output registers: clear has priority over a commit on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_COLS; c++) out_r[c] <= '0;
        end else if (bus.reset_output_reg) begin
            for (int c = 0; c < NUM_COLS; c++) out_r[c] <= '0;
        end else if (state_r == ST_COMMIT) begin
            for (int c = 0; c < NUM_COLS; c++) out_r[c] <= out_r[c] + temp_r[c];
        end
    end

    // Registered weight read-back and completion pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_output_r <= '0;
            done_r       <= 1'b0;
        end else begin
            done_r <= (state_r == ST_COMMIT);
            if (rd_en_s) begin
                mem_output_r <= weight_r[col_s][entry_s];
            end
        end
    end
endmodule

// File: tb/tb_cim_gemm_engine.sv
// Directed, table-driven bench for cim_gemm_engine with hand-computed expectations.
// Build with +define+CIM_SIGNED_ACT_EN to exercise the signed-activation variant.
module tb_cim_gemm_engine;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    cim_gemm_engine_if #(.DATA_W(32), .ACC_W(32)) bus ();

    cim_gemm_engine #(
        .ROWS(4), .WEIGHT_W(8), .ACT_W(8), .NUM_COLS(8), .DEPTH(4), .ACC_W(32), .DATA_W(32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        clr;
        logic [31:0] act;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.cs = 1'b0; bus.web = 1'b0; bus.cimeb = 1'b1; bus.partial_sum_eb = 1'b0;
        bus.reset_output_reg = 1'b0; bus.address = 32'd0; bus.input_data = 32'd0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_col(input string name, input int col, input logic [31:0] exp);
        bus.output_reg = 4'(col);
        #1;
        chk(name, bus.cim_output, exp);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus.cs = 1'b1; bus.web = 1'b1; bus.cimeb = 1'b1; bus.address = addr; bus.input_data = data;
        tick();
        idle_bus();
    endtask

    task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
        bus.cs = 1'b1; bus.web = 1'b0; bus.cimeb = 1'b1; bus.address = addr;
        tick();
        idle_bus();
        chk(name, bus.mem_output, exp);
    endtask

    task automatic clr_out();
        bus.reset_output_reg = 1'b1;
        tick();
        bus.reset_output_reg = 1'b0;
    endtask

    task automatic exec_req(input logic [31:0] act);
        bus.cs = 1'b1; bus.web = 1'b0; bus.cimeb = 1'b0; bus.partial_sum_eb = 1'b1;
        bus.address = 32'd0; bus.input_data = act;
        tick();
        idle_bus();
    endtask

    // Launch one operation and count edges until done; the latency must be ACT_W+1
    task automatic exec_op(input string name, input logic [31:0] act);
        int  n;
        logic got;
        exec_req(act);
        chk({name, "_busy"}, 32'(bus.busy), 32'd1);
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            tick();
            n++;
            if (bus.done) got = 1'b1;
        end
        chk({name, "_latency"}, 32'(n), 32'd9);
    endtask

    initial begin
        int done_cnt;
        idle_bus();
        bus.output_reg = 4'd0;

        vecs[0] = '{1'b1, 32'h01010101, 32'd6,  32'd22};
        vecs[1] = '{1'b0, 32'h02020202, 32'd18, 32'd66};
        vecs[2] = '{1'b1, 32'h00000003, 32'd0,  32'd12};
        vecs[3] = '{1'b1, 32'h03000000, 32'd9,  32'd21};
`ifdef CIM_SIGNED_ACT_EN
        vecs[4] = '{1'b1, 32'h80000000, 32'hFFFFFE80, 32'hFFFFFC80};
        vecs[5] = '{1'b0, 32'h00000000, 32'hFFFFFE80, 32'hFFFFFC80};
`else
        vecs[4] = '{1'b1, 32'h80000000, 32'd384, 32'd896};
        vecs[5] = '{1'b0, 32'h00000000, 32'd384, 32'd896};
`endif

        repeat (2) tick();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_mem_output", bus.mem_output, 32'd0);
        chk_col("rst_out0", 0, 32'd0);
        rst_n = 1'b1;
        tick();

        wr(32'd0, 32'h03020100);
        rd_chk("read_col0", 32'd0, 32'h03020100);
        wr(32'd4, 32'h07060504);
        rd_chk("read_col1", 32'd4, 32'h07060504);

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].clr) clr_out();
            exec_op($sformatf("vec%0d", i), vecs[i].act);
            chk_col($sformatf("vec%0d_out0", i), 0, vecs[i].exp0);
            chk_col($sformatf("vec%0d_out1", i), 1, vecs[i].exp1);
        end
        chk_col("sel_out_of_range", 9, 32'd0);

        // All-ones weights in column 2 against a single full-scale activation
        wr(32'd8, 32'hFFFFFFFF);
        clr_out();
        exec_op("col2", 32'h000000FF);
`ifdef CIM_SIGNED_ACT_EN
        chk_col("col2_out2", 2, 32'h00000001);
`else
        chk_col("col2_out2", 2, 32'hFFFFFF01);
`endif

        // Second request and a write while busy must both be dropped
        clr_out();
        exec_req(32'h01010101);
        done_cnt = 0;
        for (int i = 1; i <= 25; i++) begin
            if (i == 3) begin
                bus.cs = 1'b1; bus.web = 1'b0; bus.cimeb = 1'b0; bus.partial_sum_eb = 1'b1;
                bus.input_data = 32'h02020202;
            end else if (i == 5) begin
                bus.cs = 1'b1; bus.web = 1'b1; bus.cimeb = 1'b1; bus.address = 32'd0;
                bus.input_data = 32'hDEADBEEF;
            end else begin
                idle_bus();
            end
            tick();
            if (bus.done) done_cnt++;
        end
        idle_bus();
        chk("busy_single_done", 32'(done_cnt), 32'd1);
        chk_col("busy_out0", 0, 32'd6);
        chk_col("busy_out1", 1, 32'd22);
        rd_chk("busy_write_dropped", 32'd0, 32'h03020100);

        // Clear on the commit edge wins, done still pulses
        bus.output_reg = 4'd0;
        exec_req(32'h01010101);
        repeat (8) tick();
        bus.reset_output_reg = 1'b1;
        tick();
        bus.reset_output_reg = 1'b0;
        chk("clr_commit_done", 32'(bus.done), 32'd1);
        chk_col("clr_commit_out0", 0, 32'd0);
        chk_col("clr_commit_out1", 1, 32'd0);

        // Asynchronous reset in the middle of a run
        exec_op("pre_rst", 32'h01010101);
        exec_req(32'h01010101);
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk_col("midrst_out1", 1, 32'd0);
        tick();
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done) done_cnt++;
        end
        chk("midrst_no_done", 32'(done_cnt), 32'd0);
        exec_op("post_rst", 32'h01010101);
        chk_col("post_rst_out0", 0, 32'd6);
        chk_col("post_rst_out1", 1, 32'd22);

        // Activation sign handling on a unit weight
        wr(32'd0, 32'h00000001);
        clr_out();
        exec_op("act_sign", 32'h000000FF);
`ifdef CIM_SIGNED_ACT_EN
        chk_col("act_sign_out0", 0, 32'hFFFFFFFF);
`else
        chk_col("act_sign_out0", 0, 32'd255);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
